// File: rtl/decode_pkg.sv
// Shared decode definitions for instr_decode_queue: format class, MIPS opcode/func codes,
// fixed-width decoded fields and the classification/legality helpers.
package decode_pkg;

  typedef enum logic [1:0] {
    FMT_R = 2'd0,
    FMT_I = 2'd1,
    FMT_J = 2'd2
  } fmt_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  // Width-independent part of a decoded record; the top wraps it with DATA_W/PC_W fields.
  typedef struct packed {
    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shmt;
    logic [5:0] func;
    fmt_e       fmt;
  } fields_t;

  function automatic fmt_e fmt_of(input logic [5:0] op);
    case (op)
      OP_RTYPE:      return FMT_R;
      OP_J, OP_JAL:  return FMT_J;
      default:       return FMT_I;
    endcase
  endfunction

  function automatic logic is_illegal(input logic [5:0] op, input logic [5:0] fn);
    logic op_ok;
    logic fn_ok;
    op_ok = op inside {OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU,
                       OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_SW};
    fn_ok = fn inside {FN_SLL, FN_SRL, FN_JR, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
                       FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT};
    return !op_ok || ((op == OP_RTYPE) && !fn_ok);
  endfunction

endpackage

// File: rtl/decode_fifo.sv
// Generic synchronous FIFO with flush; ready is registered so it never depends on pop.
module decode_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push_req,
  input  logic                     pop_req,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     ready,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   cnt, cnt_nxt;
  logic          ready_q;
  logic          push, pop;

  assign push = push_req && ready_q && !flush && rst_n;
  assign pop  = pop_req && (cnt != '0) && !flush;

  always_comb begin
    cnt_nxt = cnt;
    case ({push, pop})
      2'b10:   cnt_nxt = cnt + (AW+1)'(1);
      2'b01:   cnt_nxt = cnt - (AW+1)'(1);
      default: cnt_nxt = cnt;
    endcase
  end

  // Reset and flush share one path; only reset holds ready low.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wptr    <= '0;
      rptr    <= '0;
      cnt     <= '0;
      ready_q <= rst_n;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      cnt     <= cnt_nxt;
      ready_q <= (cnt_nxt < (AW+1)'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  assign rdata = mem[rptr];
  assign ready = ready_q;
  assign valid = (cnt != '0);
  assign count = cnt;

endmodule

// File: rtl/instr_decode_queue.sv
// Decodes fetched MIPS instructions at push and queues the decoded records.
// Optional macro DECODE_ILLEGAL_EN stores and reports a per-entry illegal flag.
module instr_decode_queue
  import decode_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_instr,
  input  logic [PC_W-1:0]        in_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [5:0]             out_opcode,
  output logic [4:0]             out_rs,
  output logic [4:0]             out_rt,
  output logic [4:0]             out_rd,
  output logic [4:0]             out_shmt,
  output logic [5:0]             out_func,
  output logic [DATA_W-1:0]      out_imm_sext,
  output logic [DATA_W-1:0]      out_imm_zext,
  output logic [PC_W-1:0]        out_jtarget,
  output logic [1:0]             out_fmt,
  output logic [PC_W-1:0]        out_pc,
  output logic                   out_illegal,
  output logic [$clog2(DEPTH):0] count
);

  typedef struct packed {
    logic [PC_W-1:0]   jtarget;
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] sext;
    logic [DATA_W-1:0] zext;
    fields_t           f;
`ifdef DECODE_ILLEGAL_EN
    logic              ill;
`endif
  } rec_t;

  rec_t            rin, rout;
  logic [PC_W-1:0] pc4, jt;

  assign pc4 = in_pc + PC_W'(4);

  if (PC_W > 28) begin : g_jt
    assign jt = {pc4[PC_W-1:28], in_instr[25:0], 2'b00};
  end else begin : g_jt28
    assign jt = {in_instr[25:0], 2'b00};
  end

  always_comb begin
    rin           = '0;
    rin.jtarget   = jt;
    rin.pc        = in_pc;
    rin.sext      = DATA_W'(signed'(in_instr[15:0]));
    rin.zext      = DATA_W'(in_instr[15:0]);
    rin.f.opcode  = in_instr[31:26];
    rin.f.rs      = in_instr[25:21];
    rin.f.rt      = in_instr[20:16];
    rin.f.rd      = in_instr[15:11];
    rin.f.shmt    = in_instr[10:6];
    rin.f.func    = in_instr[5:0];
    rin.f.fmt     = fmt_of(in_instr[31:26]);
`ifdef DECODE_ILLEGAL_EN
    rin.ill       = is_illegal(in_instr[31:26], in_instr[5:0]);
`endif
  end

  decode_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(rec_t))
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .push_req (in_valid),
    .pop_req  (out_ready),
    .wdata    (rin),
    .rdata    (rout),
    .ready    (in_ready),
    .valid    (out_valid),
    .count    (count)
  );

  always_comb begin
    out_opcode   = '0;
    out_rs       = '0;
    out_rt       = '0;
    out_rd       = '0;
    out_shmt     = '0;
    out_func     = '0;
    out_imm_sext = '0;
    out_imm_zext = '0;
    out_jtarget  = '0;
    out_fmt      = '0;
    out_pc       = '0;
    out_illegal  = 1'b0;
    if (out_valid) begin
      out_opcode   = rout.f.opcode;
      out_rs       = rout.f.rs;
      out_rt       = rout.f.rt;
      out_rd       = rout.f.rd;
      out_shmt     = rout.f.shmt;
      out_func     = rout.f.func;
      out_imm_sext = rout.sext;
      out_imm_zext = rout.zext;
      out_jtarget  = rout.jtarget;
      out_fmt      = rout.f.fmt;
      out_pc       = rout.pc;
`ifdef DECODE_ILLEGAL_EN
      out_illegal  = rout.ill;
`endif
    end
  end

endmodule

// File: tb/tb_instr_decode_queue.sv
// Directed self-checking bench for instr_decode_queue (DEPTH=2, 32-bit widths).
module tb_instr_decode_queue;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [31:0] in_instr, in_pc, out_imm_sext, out_imm_zext, out_jtarget, out_pc;
  logic [5:0]  out_opcode, out_func;
  logic [4:0]  out_rs, out_rt, out_rd, out_shmt;
  logic [1:0]  out_fmt;
  logic [1:0]  count;

  int n_cmp = 0;
  int n_bad = 0;
  logic exp_ill;

  always #5 clk = ~clk;

  instr_decode_queue #(.DATA_W(32), .PC_W(32), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
    .out_shmt(out_shmt), .out_func(out_func),
    .out_imm_sext(out_imm_sext), .out_imm_zext(out_imm_zext),
    .out_jtarget(out_jtarget), .out_fmt(out_fmt), .out_pc(out_pc),
    .out_illegal(out_illegal), .count(count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc, input logic rdy);
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = rdy;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    repeat (3) step();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_count", count, 0);
    check("rst_opcode", out_opcode, 0);
    check("rst_pc", out_pc, 0);

    rst_n = 1'b1;
    step();
    check("post_rst_ready", in_ready, 1);

    // add $8,$9,$10
    drive(1'b1, 32'h012A4020, 32'h00400000, 1'b0);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    check("add_valid", out_valid, 1);
    check("add_fmt", out_fmt, 0);
    check("add_rs", out_rs, 9);
    check("add_rt", out_rt, 10);
    check("add_rd", out_rd, 8);
    check("add_func", out_func, 6'h20);
    check("add_illegal", out_illegal, 0);
    check("add_pc", out_pc, 32'h00400000);
    check("add_count", count, 1);

    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("pop_valid", out_valid, 0);
    check("pop_count", count, 0);
    check("pop_zero_rs", out_rs, 0);

    // addi $8,$8,-1
    drive(1'b1, 32'h2108FFFF, 32'h00400004, 1'b0);
    step();
    check("addi_fmt", out_fmt, 1);
    check("addi_sext", out_imm_sext, 32'hFFFFFFFF);
    check("addi_zext", out_imm_zext, 32'h0000FFFF);
    check("addi_rt", out_rt, 8);

    // j pushed while addi pops
    drive(1'b1, 32'h08100004, 32'h40000000, 1'b1);
    step();
    check("j_count", count, 1);
    check("j_fmt", out_fmt, 2);
    check("j_target", out_jtarget, 32'h40400010);
    check("j_pc", out_pc, 32'h40000000);
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    step();
    check("drain_count", count, 0);

    // fill to DEPTH
    drive(1'b1, 32'h2108FFFF, 32'h00000100, 1'b0);
    step();
    drive(1'b1, 32'h012A4020, 32'h00000104, 1'b0);
    step();
    check("full_count", count, 2);
    check("full_ready", in_ready, 0);
    check("full_head", out_pc, 32'h00000100);
    drive(1'b1, 32'h08100004, 32'h00000108, 1'b1);
    step();
    check("full_pop_count", count, 1);
    check("full_pop_ready", in_ready, 1);
    check("full_pop_head", out_pc, 32'h00000104);
    drive(1'b1, 32'h08100004, 32'h00000108, 1'b0);
    step();
    check("late_push_count", count, 2);
    check("late_push_head", out_pc, 32'h00000104);
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    step();
    check("late_head_pc", out_pc, 32'h00000108);
    check("late_head_op", out_opcode, 6'h02);
    step();
    check("late_drain", count, 0);

    // flush with full queue and concurrent in_valid
    drive(1'b1, 32'h012A4020, 32'h00000200, 1'b0);
    step();
    drive(1'b1, 32'h012A4020, 32'h00000204, 1'b0);
    step();
    flush = 1'b1;
    drive(1'b1, 32'h2108FFFF, 32'h00000300, 1'b1);
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    check("flush_count", count, 0);
    check("flush_valid", out_valid, 0);
    check("flush_ready", in_ready, 1);
    step();
    check("flush_no_store", count, 0);

    // flush with room: the same-cycle push must still be dropped
    drive(1'b1, 32'h012A4020, 32'h00000400, 1'b0);
    step();
    flush = 1'b1;
    drive(1'b1, 32'h2108FFFF, 32'h00000404, 1'b0);
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    check("flush1_count", count, 0);
    check("flush1_valid", out_valid, 0);

`ifdef DECODE_ILLEGAL_EN
    exp_ill = 1'b1;
`else
    exp_ill = 1'b0;
`endif
    drive(1'b1, 32'hFC000000, 32'h00000500, 1'b1);
    step();
    drive(1'b1, 32'h0000003F, 32'h00000504, 1'b1);
    check("ill_opcode", out_illegal, exp_ill);
    check("ill_opcode_fmt", out_fmt, 1);
    step();
    drive(1'b1, 32'h2108FFFF, 32'h00000508, 1'b1);
    check("ill_func", out_illegal, exp_ill);
    check("ill_func_fmt", out_fmt, 0);
    step();
    drive(1'b1, 32'h012A4020, 32'h0000050C, 1'b1);
    check("legal_addi", out_illegal, 0);
    check("stream_pc0", out_pc, 32'h00000508);
    check("stream_count", count, 1);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    check("stream_pc1", out_pc, 32'h0000050C);

    // reset mid-stream drops entries
    rst_n = 1'b0;
    step();
    check("mid_rst_count", count, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_ready", in_ready, 0);
    rst_n = 1'b1;
    step();
    check("mid_rel_ready", in_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
